// File: rtl/dmem_arbiter_if.sv
// One requester port of the data-memory arbiter: a command from the requester
// and a registered acknowledge, read word and error flag back to it.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              ack;
    logic [DATA_W-1:0] rdata;
    logic              err;

    modport master (output req, we, addr, wdata, input ack, rdata, err);
    modport slave  (input req, we, addr, wdata, output ack, rdata, err);
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin two-port arbiter/sequencer for the single data memory (IDLE -> ACCESS -> RESPOND).
// Define DMEM_ARB_ALIGN_CHECK_EN to reject word accesses with addr[1:0] != 0 without touching memory.
module dmem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    dmem_arbiter_if.slave     a,
    dmem_arbiter_if.slave     b,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESPOND} state_e;
    typedef enum logic {PORT_A, PORT_B} port_e;

    state_e            state, state_d;
    port_e             last_grant, winner;
    logic              grant, misalign_sel;
    logic              a_live, b_live;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              cmd_we, cmd_err;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              a_ack_q, b_ack_q;
    logic [DATA_W-1:0] a_rdata_q, b_rdata_q;

    // A request still high while any ack is out belongs to the transaction just finished.
    assign a_live = a.req && !(a_ack_q || b_ack_q);
    assign b_live = b.req && !(a_ack_q || b_ack_q);

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_d      = state;
        grant        = 1'b0;
        winner       = PORT_A;
        misalign_sel = 1'b0;
        if (b_live && (!a_live || last_grant == PORT_A))
            winner = PORT_B;
        sel_we    = (winner == PORT_B) ? b.we    : a.we;
        sel_addr  = (winner == PORT_B) ? b.addr  : a.addr;
        sel_wdata = (winner == PORT_B) ? b.wdata : a.wdata;
`ifdef DMEM_ARB_ALIGN_CHECK_EN
        misalign_sel = (sel_addr[1:0] != 2'b00);
`endif
        case (state)
            IDLE: begin
                if (a_live || b_live) begin
                    grant   = 1'b1;
                    state_d = misalign_sel ? RESPOND : ACCESS;
                end
            end
            ACCESS:  state_d = RESPOND;
            RESPOND: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset)
            state <= IDLE;
        else
            state <= state_d;
    end

    // Command latch, memory strobes and per-port responses, all registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= PORT_B;
            cmd_we     <= 1'b0;
            cmd_err    <= 1'b0;
            cmd_addr   <= '0;
            cmd_wdata  <= '0;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            a_ack_q    <= 1'b0;
            b_ack_q    <= 1'b0;
            a_rdata_q  <= '0;
            b_rdata_q  <= '0;
        end else begin
            mem_read  <= grant && !misalign_sel && !sel_we;
            mem_write <= grant && !misalign_sel && sel_we;
            a_ack_q   <= (state == RESPOND) && (last_grant == PORT_A);
            b_ack_q   <= (state == RESPOND) && (last_grant == PORT_B);
            if (grant) begin
                last_grant <= winner;
                cmd_we     <= sel_we;
                cmd_err    <= misalign_sel;
                cmd_addr   <= sel_addr;
                cmd_wdata  <= sel_wdata;
            end
            if (state == RESPOND && (cmd_err || !cmd_we)) begin
                if (last_grant == PORT_A)
                    a_rdata_q <= cmd_err ? '0 : mem_rdata;
                else
                    b_rdata_q <= cmd_err ? '0 : mem_rdata;
            end
        end
    end

`ifdef DMEM_ARB_ALIGN_CHECK_EN
    logic a_err_q, b_err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            a_err_q <= 1'b0;
            b_err_q <= 1'b0;
        end else begin
            a_err_q <= (state == RESPOND) && (last_grant == PORT_A) && cmd_err;
            b_err_q <= (state == RESPOND) && (last_grant == PORT_B) && cmd_err;
        end
    end

    assign a.err = a_err_q;
    assign b.err = b_err_q;
`else
    assign a.err = 1'b0;
    assign b.err = 1'b0;
`endif

    assign a.ack     = a_ack_q;
    assign b.ack     = b_ack_q;
    assign a.rdata   = a_rdata_q;
    assign b.rdata   = b_rdata_q;
    assign mem_addr  = cmd_addr;
    assign mem_wdata = cmd_wdata;
    assign busy      = (state != IDLE);
endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus random traffic
// compared against a transaction-level timing/data model and a word memory.
module tb_dmem_arbiter;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_read, mem_write, busy;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    dmem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) a_if ();
    dmem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) b_if ();

    dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .a         (a_if),
        .b         (b_if),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Data memory stand-in: word array, read data registered on the strobe edge.
    logic [31:0] mem [0:63] = '{default: '0};
    always @(posedge clk) begin
        if (mem_write) mem[mem_addr[7:2]] <= mem_wdata;
        if (mem_read)  mem_rdata <= mem[mem_addr[7:2]];
    end

    // Reference model state.
    logic [31:0] ref_mem [0:63] = '{default: '0};
    logic [31:0] exp_rdata [2];
    int          exp_last;   // 0 = A, 1 = B
    int          tests = 0;
    int          fails = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit misaligned(input logic [31:0] addr);
`ifdef DMEM_ARB_ALIGN_CHECK_EN
        return addr[1:0] != 2'b00;
`else
        return 1'b0;
`endif
    endfunction

    task automatic set_req(input int p, input bit v);
        if (p == 0) a_if.req = v;
        else        b_if.req = v;
    endtask

    task automatic model_reset();
        exp_last     = 1;
        exp_rdata[0] = '0;
        exp_rdata[1] = '0;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_reset();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".a_ack"},     a_if.ack,   '0);
        check({tag, ".b_ack"},     b_if.ack,   '0);
        check({tag, ".a_err"},     a_if.err,   '0);
        check({tag, ".b_err"},     b_if.err,   '0);
        check({tag, ".a_rdata"},   a_if.rdata, '0);
        check({tag, ".b_rdata"},   b_if.rdata, '0);
        check({tag, ".mem_read"},  mem_read,   '0);
        check({tag, ".mem_write"}, mem_write,  '0);
        check({tag, ".mem_addr"},  mem_addr,   '0);
        check({tag, ".mem_wdata"}, mem_wdata,  '0);
        check({tag, ".busy"},      busy,       '0);
    endtask

    // Issue up to one request per port at once and check every cycle until both are done.
    // Timing rules: grant edge g, ack at g+2 (g+1 when rejected as misaligned),
    // the ack cycle ignores requests, so a waiting port is granted at ack+2.
    task automatic txn(input string tag,
                       input bit on_a, input bit on_b,
                       input bit we_a, input bit we_b,
                       input logic [31:0] addr_a, input logic [31:0] addr_b,
                       input logic [31:0] wd_a, input logic [31:0] wd_b,
                       input bit hold_a, input bit hold_b);
        int          n = 0;
        int          port[2];
        int          g[2];
        int          ack[2];
        bit          mis[2];
        bit          we[2];
        bit          hold[2];
        logic [31:0] ad[2];
        logic [31:0] wd[2];
        int          last_t;
        we[0] = we_a;     we[1] = we_b;
        ad[0] = addr_a;   ad[1] = addr_b;
        wd[0] = wd_a;     wd[1] = wd_b;
        hold[0] = hold_a; hold[1] = hold_b;
        if (on_a && on_b) begin
            port[0] = (exp_last == 1) ? 0 : 1;
            port[1] = 1 - port[0];
            n = 2;
        end else if (on_a) begin
            port[0] = 0; n = 1;
        end else if (on_b) begin
            port[0] = 1; n = 1;
        end
        for (int i = 0; i < n; i++) begin
            mis[i] = misaligned(ad[port[i]]);
            g[i]   = (i == 0) ? 1 : ack[i-1] + 2;
            ack[i] = g[i] + (mis[i] ? 1 : 2);
        end
        if (n > 0) exp_last = port[n-1];
        last_t = (n > 0) ? ack[n-1] + 2 : 3;

        a_if.we = we_a; a_if.addr = addr_a; a_if.wdata = wd_a; a_if.req = on_a;
        b_if.we = we_b; b_if.addr = addr_b; b_if.wdata = wd_b; b_if.req = on_b;

        for (int t = 1; t <= last_t; t++) begin
            bit e_ack[2];
            bit e_rd, e_wr, e_busy;
            tick();
            e_ack[0] = 0; e_ack[1] = 0; e_rd = 0; e_wr = 0; e_busy = 0;
            for (int i = 0; i < n; i++) begin
                int p = port[i];
                if (t >= g[i] && t < ack[i]) e_busy = 1;
                if (t == g[i] && !mis[i]) begin
                    if (we[p]) e_wr = 1; else e_rd = 1;
                    check({tag, ".mem_addr"}, mem_addr, ad[p]);
                    if (we[p]) check({tag, ".mem_wdata"}, mem_wdata, wd[p]);
                end
                if (t == ack[i]) begin
                    e_ack[p] = 1;
                    if (mis[i])      exp_rdata[p] = '0;
                    else if (!we[p]) exp_rdata[p] = ref_mem[ad[p][7:2]];
                    else             ref_mem[ad[p][7:2]] = wd[p];
                    check({tag, (p == 0) ? ".a_err" : ".b_err"},
                          (p == 0) ? a_if.err : b_if.err, mis[i]);
                end
            end
            check({tag, ".a_ack"},     a_if.ack,   e_ack[0]);
            check({tag, ".b_ack"},     b_if.ack,   e_ack[1]);
            check({tag, ".busy"},      busy,       e_busy);
            check({tag, ".mem_read"},  mem_read,   e_rd);
            check({tag, ".mem_write"}, mem_write,  e_wr);
            check({tag, ".a_rdata"},   a_if.rdata, exp_rdata[0]);
            check({tag, ".b_rdata"},   b_if.rdata, exp_rdata[1]);
            for (int i = 0; i < n; i++) begin
                if (t == ack[i] && !hold[port[i]])    set_req(port[i], 0);
                if (t == ack[i] + 1 && hold[port[i]]) set_req(port[i], 0);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        a_if.req = 0; a_if.we = 0; a_if.addr = '0; a_if.wdata = '0;
        b_if.req = 0; b_if.we = 0; b_if.addr = '0; b_if.wdata = '0;
        tick();
        tick();
        check_all_zero("reset");
        reset = 1'b0;
        model_reset();

        txn("a_write", 1, 0, 1, 0, 32'h8, 32'h0, 32'h077F_DFF0, 32'h0, 0, 0);
        txn("b_read",  0, 1, 0, 0, 32'h0, 32'h8, 32'h0, 32'h0, 0, 0);
        check("b_read.value", b_if.rdata, 32'h077F_DFF0);

        apply_reset();
        txn("tie", 1, 1, 1, 0, 32'h0, 32'h0, 32'h1111_1111, 32'h0, 0, 0);
        check("tie.value", b_if.rdata, 32'h1111_1111);
        txn("alt1", 1, 1, 1, 1, 32'h20, 32'h24, 32'hA5A5_0001, 32'h5A5A_0002, 0, 0);
        txn("alt2", 1, 1, 0, 0, 32'h24, 32'h20, 32'h0, 32'h0, 0, 0);

        // Reset while a B read is in ACCESS: no ack, everything back to zero.
        apply_reset();
        b_if.req = 1; b_if.we = 0; b_if.addr = 32'h10;
        tick();
        check("abort.mem_read", mem_read, 1'b1);
        reset = 1'b1;
        tick();
        check_all_zero("abort");
        reset = 1'b0;
        b_if.req = 0;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            tick();
            check("abort.no_b_ack", b_if.ack, 1'b0);
        end
        txn("abort_tie", 1, 1, 0, 1, 32'h14, 32'h18, 32'h0, 32'hCAFE_F00D, 0, 0);

        txn("align_rd", 1, 0, 0, 0, 32'h6, 32'h0, 32'h0, 32'h0, 0, 0);
        txn("align_wr", 1, 0, 1, 0, 32'h5, 32'h0, 32'hDEAD_BEEF, 32'h0, 0, 0);
        txn("align_chk", 0, 1, 0, 0, 32'h0, 32'h4, 32'h0, 32'h0, 0, 0);

        txn("ack_hold", 1, 0, 0, 0, 32'h18, 32'h0, 32'h0, 32'h0, 1, 0);

        for (int k = 0; k < 40; k++) begin
            bit ra, rb;
            ra = 1'($urandom_range(0, 1));
            rb = 1'($urandom_range(0, 1));
            if (!ra && !rb) ra = 1;
            txn("rand", ra, rb,
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                $urandom() & 32'hFFFF_FFFC, $urandom() & 32'hFFFF_FFFC,
                $urandom(), $urandom(),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
